// File: rtl/prio_enc_rr_pkg.sv
// prio_enc_pkg: priority mode constants and the wrapping decrement shared by scan and pointer update.
package prio_enc_pkg;
    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR = 1;
    function automatic int wrap_dec(input int idx, input int n);
        return (idx == 0) ? n - 1 : idx - 1;
    endfunction
endpackage

// File: rtl/prio_enc_rr_if.sv
// prio_enc_rr_if: request/result handshake bundle; out_onehot exists only with PRIO_ENC_RR_ONEHOT_EN.
interface prio_enc_rr_if #(
    parameter int N = 8,
    localparam int IDX_W = $clog2(N)
);
    logic en;
    logic [N-1:0] req;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    logic [IDX_W-1:0] out_idx;
    logic out_any;
`ifdef PRIO_ENC_RR_ONEHOT_EN
    logic [N-1:0] out_onehot;
`endif
    modport master (
        output en, req, in_valid, out_ready,
        input in_ready, out_valid, out_idx, out_any
`ifdef PRIO_ENC_RR_ONEHOT_EN
        , input out_onehot
`endif
    );
    modport slave (
        input en, req, in_valid, out_ready,
        output in_ready, out_valid, out_idx, out_any
`ifdef PRIO_ENC_RR_ONEHOT_EN
        , output out_onehot
`endif
    );
endinterface

// File: rtl/prio_enc_rr_core.sv
// prio_enc_core: combinational downward scan from start, wrapping 0 -> N-1; first set bit wins.
module prio_enc_core
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin
        logic [IDX_W-1:0] p;
        idx = '0;
        any = 1'b0;
        p = start;
        for (int k = 0; k < N; k++) begin
            if (!any && req[p]) begin
                idx = p;
                any = 1'b1;
            end
            p = IDX_W'(wrap_dec(32'(p), N));
        end
    end
endmodule

// File: rtl/prio_enc_rr.sv
// prio_enc_rr: registered N-input priority encoder, fixed or round-robin, valid/ready handshake.
// Optional registered one-hot winner output with PRIO_ENC_RR_ONEHOT_EN.
module prio_enc_rr
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    parameter int ROTATE = PRIO_FIXED,
    localparam int IDX_W = $clog2(N)
) (
    input logic clk,
    input logic rst,
    prio_enc_rr_if.slave bus
);
    logic [IDX_W-1:0] ptr, start, idx;
    logic any, cap;
    assign bus.in_ready = bus.en && (!bus.out_valid || bus.out_ready);
    assign cap = bus.in_valid && bus.in_ready;
    assign start = (ROTATE == PRIO_RR) ? ptr : IDX_W'(N - 1);
    prio_enc_core #(.N(N)) u_core (.req(bus.req), .start(start), .idx(idx), .any(any));
    // ptr only moves past a real winner, so it stays within 0..N-1 for any N
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_idx <= '0;
            bus.out_any <= 1'b0;
            ptr <= IDX_W'(N - 1);
`ifdef PRIO_ENC_RR_ONEHOT_EN
            bus.out_onehot <= '0;
`endif
        end else if (cap) begin
            bus.out_valid <= 1'b1;
            bus.out_idx <= idx;
            bus.out_any <= any;
            if (any) ptr <= IDX_W'(wrap_dec(32'(idx), N));
`ifdef PRIO_ENC_RR_ONEHOT_EN
            bus.out_onehot <= any ? (N'(1) << idx) : '0;
`endif
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_prio_enc_rr.sv
// tb_prio_enc_rr: three instances (N=8 fixed, N=8 round-robin, N=5 round-robin) against a bench model.
module tb_prio_enc_rr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int cmp = 0;
    int mis = 0;
    logic en [3];
    logic vld [3];
    logic rdy [3];
    logic [7:0] rq [3];
    logic [2:0] di [3];
    logic dv [3], da [3], dr [3];
    logic [7:0] doh [3];
    int nn [3] = '{8, 8, 5};
    int rot [3] = '{0, 1, 1};
    bit mv [3], ma [3];
    int mi [3], mp [3];
    prio_enc_rr_if #(.N(8)) b8f ();
    prio_enc_rr_if #(.N(8)) b8r ();
    prio_enc_rr_if #(.N(5)) b5r ();
    prio_enc_rr #(.N(8), .ROTATE(0)) u8f (.clk(clk), .rst(rst), .bus(b8f));
    prio_enc_rr #(.N(8), .ROTATE(1)) u8r (.clk(clk), .rst(rst), .bus(b8r));
    prio_enc_rr #(.N(5), .ROTATE(1)) u5r (.clk(clk), .rst(rst), .bus(b5r));
    assign b8f.en = en[0];
    assign b8f.in_valid = vld[0];
    assign b8f.out_ready = rdy[0];
    assign b8f.req = rq[0];
    assign b8r.en = en[1];
    assign b8r.in_valid = vld[1];
    assign b8r.out_ready = rdy[1];
    assign b8r.req = rq[1];
    assign b5r.en = en[2];
    assign b5r.in_valid = vld[2];
    assign b5r.out_ready = rdy[2];
    assign b5r.req = rq[2][4:0];
    assign di[0] = b8f.out_idx;
    assign di[1] = b8r.out_idx;
    assign di[2] = b5r.out_idx;
    assign dv[0] = b8f.out_valid;
    assign dv[1] = b8r.out_valid;
    assign dv[2] = b5r.out_valid;
    assign da[0] = b8f.out_any;
    assign da[1] = b8r.out_any;
    assign da[2] = b5r.out_any;
    assign dr[0] = b8f.in_ready;
    assign dr[1] = b8r.in_ready;
    assign dr[2] = b5r.in_ready;
`ifdef PRIO_ENC_RR_ONEHOT_EN
    assign doh[0] = b8f.out_onehot;
    assign doh[1] = b8r.out_onehot;
    assign doh[2] = {3'b000, b5r.out_onehot};
`else
    assign doh[0] = 8'h00;
    assign doh[1] = 8'h00;
    assign doh[2] = 8'h00;
`endif

    task automatic chk(input string nm, input int act, input int exp);
        cmp++;
        if (act != exp) begin
            mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // first set bit seen walking down from st modulo n; -1 when none
    function automatic int enc(input logic [7:0] r, input int n, input int st);
        for (int k = 0; k < n; k++)
            if (r[(st - k + n) % n]) return (st - k + n) % n;
        return -1;
    endfunction

    function automatic int win(input int j);
        return enc(rq[j], nn[j], rot[j] != 0 ? mp[j] : nn[j] - 1);
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int j = 0; j < 3; j++) begin
            if (rst) begin
                mv[j] <= 1'b0;
                mi[j] <= 0;
                ma[j] <= 1'b0;
                mp[j] <= nn[j] - 1;
            end else if (vld[j] && en[j] && (!mv[j] || rdy[j])) begin
                mv[j] <= 1'b1;
                mi[j] <= win(j) < 0 ? 0 : win(j);
                ma[j] <= win(j) >= 0;
                if (rot[j] != 0 && win(j) >= 0) mp[j] <= (win(j) + nn[j] - 1) % nn[j];
            end else if (rdy[j]) begin
                mv[j] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("in_ready[%0d]", j), int'(dr[j]), int'(en[j] && (!mv[j] || rdy[j])));
            chk($sformatf("out_valid[%0d]", j), int'(dv[j]), int'(mv[j]));
            chk($sformatf("out_idx[%0d]", j), int'(di[j]), mi[j]);
            chk($sformatf("out_any[%0d]", j), int'(da[j]), int'(ma[j]));
`ifdef PRIO_ENC_RR_ONEHOT_EN
            chk($sformatf("out_onehot[%0d]", j), int'(doh[j]), ma[j] ? (1 << mi[j]) : 0);
`endif
        end
        chk("ptr5_range", int'(u5r.ptr < 3'd5), 1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int seq8 [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int seq5 [4] = '{4, 0, 4, 0};

    initial begin
        for (int j = 0; j < 3; j++) begin
            en[j] = 1'b1;
            vld[j] = 1'b0;
            rdy[j] = 1'b1;
            rq[j] = 8'h00;
        end
        cyc();
        cyc();
        chk("rst_valid", int'(dv[0]), 0);
        chk("rst_idx", int'(di[1]), 0);
        chk("rst_any", int'(da[2]), 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", int'(dr[0]), 1);
        // fixed priority: highest set bit, then empty request
        rq[0] = 8'b0010_1100;
        vld[0] = 1'b1;
        cyc();
        chk("fix_valid", int'(dv[0]), 1);
        chk("fix_idx", int'(di[0]), 5);
        chk("fix_any", int'(da[0]), 1);
        rq[0] = 8'h00;
        cyc();
        chk("fix_zero_idx", int'(di[0]), 0);
        chk("fix_zero_any", int'(da[0]), 0);
        chk("fix_zero_valid", int'(dv[0]), 1);
        vld[0] = 1'b0;
        cyc();
        chk("fix_drained", int'(dv[0]), 0);
        // round-robin N=8 on all-ones
        rq[1] = 8'hFF;
        vld[1] = 1'b1;
        for (int s = 0; s < 9; s++) begin
            cyc();
            chk($sformatf("rr8_seq%0d", s), int'(di[1]), seq8[s]);
        end
        vld[1] = 1'b0;
        cyc();
        // round-robin N=5, non-power-of-two wrap
        rq[2] = 8'b0001_0001;
        vld[2] = 1'b1;
        for (int s = 0; s < 4; s++) begin
            cyc();
            chk($sformatf("rr5_seq%0d", s), int'(di[2]), seq5[s]);
        end
        vld[2] = 1'b0;
        cyc();
        // backpressure holds the result
        rq[0] = 8'h10;
        vld[0] = 1'b1;
        cyc();
        chk("bp_first", int'(di[0]), 4);
        rq[0] = 8'h02;
        rdy[0] = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("bp_in_ready", int'(dr[0]), 0);
            cyc();
            chk("bp_hold_idx", int'(di[0]), 4);
            chk("bp_hold_valid", int'(dv[0]), 1);
        end
        rdy[0] = 1'b1;
        cyc();
        chk("bp_next", int'(di[0]), 1);
        vld[0] = 1'b0;
        cyc();
        chk("bp_drained", int'(dv[0]), 0);
        // en=0 blocks capture, pending result still drains
        rq[0] = 8'h08;
        vld[0] = 1'b1;
        rdy[0] = 1'b0;
        cyc();
        chk("en_prior", int'(di[0]), 3);
        en[0] = 1'b0;
        rq[0] = 8'h80;
        #1;
        chk("en_in_ready", int'(dr[0]), 0);
        cyc();
        chk("en_hold_idx", int'(di[0]), 3);
        rdy[0] = 1'b1;
        cyc();
        chk("en_drain_valid", int'(dv[0]), 0);
        chk("en_drain_idx", int'(di[0]), 3);
        cyc();
        chk("en_no_capture", int'(dv[0]), 0);
        en[0] = 1'b1;
        vld[0] = 1'b0;
        // async reset in the middle of round-robin traffic
        rq[1] = 8'h40;
        vld[1] = 1'b1;
        cyc();
        chk("rst_mid_win6", int'(di[1]), 6);
        rq[1] = 8'hFF;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", int'(dv[1]), 0);
        chk("rst_mid_idx", int'(di[1]), 0);
        chk("rst_mid_any", int'(da[1]), 0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("rst_mid_after", int'(di[1]), 7);
        vld[1] = 1'b0;
        cyc();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule
